// File: rtl/irrigation_request_fsm_pkg.sv
// Shared types and constants for the irrigation request stage.
// State encodings, tank codes and sensor-vector bit positions.
package irrigation_request_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_IRRIGATE = 2'b01,
        ST_REFILL   = 2'b10,
        ST_ALARM    = 2'b11
    } state_t;

    localparam logic [2:0] TANK_EMPTY = 3'b000;
    localparam logic [2:0] TANK_LOW   = 3'b100;
    localparam logic [2:0] TANK_MID   = 3'b110;
    localparam logic [2:0] TANK_FULL  = 3'b111;

    localparam int SENS_W = 5;
    localparam int S_DRY  = 4;
    localparam int S_WET  = 3;
    localparam int S_LOW  = 2;
    localparam int S_MID  = 1;
    localparam int S_HIGH = 0;

    // Soil probes must not both fire; tank probes must be thermometer-coded.
    function automatic logic vec_ok(input logic [SENS_W-1:0] v);
        logic [2:0] tank;
        tank = {v[S_LOW], v[S_MID], v[S_HIGH]};
        return !(v[S_DRY] && v[S_WET]) &&
               ((tank == TANK_EMPTY) || (tank == TANK_LOW) ||
                (tank == TANK_MID)   || (tank == TANK_FULL));
    endfunction

endpackage

// File: rtl/irrigation_request_fsm_if.sv
// Sensor inputs and request/status outputs of the irrigation request stage.
interface irrigation_request_fsm_if;

    logic       systemOn;
    logic       soilDry;
    logic       soilWet;
    logic       tankLow;
    logic       tankMid;
    logic       tankHigh;
    logic       irrigationRequest;
    logic       valveFill;
    logic       alarm;
    logic [1:0] state;

    modport master (
        output systemOn, soilDry, soilWet, tankLow, tankMid, tankHigh,
        input  irrigationRequest, valveFill, alarm, state
    );

    modport slave (
        input  systemOn, soilDry, soilWet, tankLow, tankMid, tankHigh,
        output irrigationRequest, valveFill, alarm, state
    );

endinterface

// File: rtl/irrigation_request_fsm_debounce.sv
// 2-FF synchroniser plus stability counter for a vector of raw probes.
module sensor_debounce #(
    parameter int W               = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_vec,
    output logic         o_valid
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     r_sync1;
    logic [W-1:0]     r_sync2;
    logic [W-1:0]     r_prev;
    logic [W-1:0]     r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    logic             w_same;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;

    always_comb begin
        w_same    = (r_sync2 == r_prev);
        w_cnt_nxt = '0;
        if (w_same) begin
            w_cnt_nxt = (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
        w_load = (w_cnt_nxt == LP_CNT_MAX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_vec   <= r_sync2;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_vec   = r_vec;
    assign o_valid = r_valid;

endmodule

// File: rtl/irrigation_request_fsm.sv
// Decides irrigation requests and tank refills from debounced probes.
module irrigation_request_fsm
    import irrigation_request_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES       = 4,
    parameter int MIN_IRRIGATION_CYCLES = 16,
    parameter int CNT_W                 = 8
) (
    input  logic clock,
    input  logic resetBar,
    irrigation_request_fsm_if.slave bus
);

    localparam logic [CNT_W-1:0] LP_MIN_MAX =
        CNT_W'(MIN_IRRIGATION_CYCLES - 1);

    logic [SENS_W-1:0] w_raw;
    logic [SENS_W-1:0] w_vec;
    logic              w_valid;
    logic              w_ok;
    logic              w_empty;
    logic              w_full;
    logic              w_min_done;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_min_cnt;

    assign w_raw = {bus.soilDry, bus.soilWet,
                    bus.tankLow, bus.tankMid, bus.tankHigh};

    sensor_debounce #(
        .W               (SENS_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .i_clk   (clock),
        .i_rst_n (resetBar),
        .i_raw   (w_raw),
        .o_vec   (w_vec),
        .o_valid (w_valid)
    );

    assign w_ok       = vec_ok(w_vec);
    assign w_empty    = ({w_vec[S_LOW], w_vec[S_MID], w_vec[S_HIGH]} == TANK_EMPTY);
    assign w_full     = ({w_vec[S_LOW], w_vec[S_MID], w_vec[S_HIGH]} == TANK_FULL);
    assign w_min_done = (r_min_cnt >= LP_MIN_MAX);

    always_ff @(posedge clock or negedge resetBar) begin
        if (!resetBar) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_valid) begin
            w_state_nxt = ST_IDLE;
        end else if (!w_ok) begin
            w_state_nxt = ST_ALARM;
        end else if (r_state == ST_ALARM) begin
            w_state_nxt = bus.systemOn ? ST_ALARM : ST_IDLE;
        end else if (!bus.systemOn) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_empty)                 w_state_nxt = ST_REFILL;
                    else if (w_vec[S_DRY])       w_state_nxt = ST_IRRIGATE;
                end
                ST_IRRIGATE: begin
                    if (w_empty)                 w_state_nxt = ST_REFILL;
                    else if (w_vec[S_WET] && w_min_done)
                                                 w_state_nxt = ST_IDLE;
                end
                ST_REFILL: begin
                    if (w_full)                  w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Cleared on the entry edge, then counts each cycle spent irrigating.
    always_ff @(posedge clock or negedge resetBar) begin
        if (!resetBar) begin
            r_min_cnt <= '0;
        end else if (r_state != ST_IRRIGATE && w_state_nxt == ST_IRRIGATE) begin
            r_min_cnt <= '0;
        end else if (r_state == ST_IRRIGATE && !w_min_done) begin
            r_min_cnt <= r_min_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.irrigationRequest = (r_state == ST_IRRIGATE);
        bus.valveFill         = (r_state == ST_REFILL);
        bus.alarm             = (r_state == ST_ALARM);
        bus.state             = r_state;
    end

endmodule

// File: doc/irrigation_request_fsm.md
Name: irrigation_request_fsm

Overview:
- Upstream stage of the irrigation controller. Conditions the raw soil-humidity and water-tank probes: 2-FF synchronisation, then debounce.
- Runs a 4-state Moore FSM that decides when irrigation is requested and when the tank must be refilled.
- `irrigationRequest` drives the `cIn` input of the irrigation-mode FSM directly downstream. The alarm flags invalid sensor combinations.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required before the sensor vector is accepted (≥1).
- MIN_IRRIGATION_CYCLES, 16: minimum cycles spent in IRRIGATE before a wet reading may end it (≥1).
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, MIN_IRRIGATION_CYCLES).

Ports:
- clock  in  1  system clock, rising edge.
- resetBar  in  1  asynchronous, active-low reset.
- systemOn  in  1  master enable switch (level).
- soilDry  in  1  raw probe, 1 = soil dry.
- soilWet  in  1  raw probe, 1 = soil wet.
- tankLow  in  1  raw level probe, 1 = water at low mark.
- tankMid  in  1  raw level probe, 1 = water at mid mark.
- tankHigh  in  1  raw level probe, 1 = water at high mark.
- irrigationRequest  out  1  request to irrigate; feeds downstream `cIn`.
- valveFill  out  1  tank refill valve open.
- alarm  out  1  invalid-sensor alarm.
- state  out  2  current FSM state, for debug/LEDs.

Behaviour:
- Reset (resetBar=0, asynchronous) clears:
  - the sync flops, debounce counter, accepted vector, `sensorsValid` flag, min counter;
  - state=IDLE; all outputs 0.
- Release is synchronous to the next rising edge.
- Sensor vector S = {soilDry, soilWet, tankLow, tankMid, tankHigh}, synchronised through 2 flops.
- Debounce:
  - If the synced S differs from the previous synced sample, the counter goes to 0.
  - Otherwise the counter increments, saturating.
  - When the count reaches DEBOUNCE_CYCLES-1, the synced S is loaded into the accepted vector and `sensorsValid` is set.
  - `sensorsValid` stays set until reset.
  - Latency: a raw change held stable appears in the accepted vector 2+DEBOUNCE_CYCLES edges later. The state/outputs respond 1 edge after that.
- Validity of the accepted vector:
  - soilDry & soilWet = invalid.
  - Tank must be thermometer-coded (low,mid,high) in {000, 100, 110, 111}; anything else is invalid.
  - Tank empty = 000. Tank full = 111.
- While `sensorsValid`=0 the FSM holds IDLE.
- Transition priority each edge (first match wins):
  1. Accepted vector invalid → ALARM, from any state.
  2. ALARM: leave to IDLE only when the vector is valid AND systemOn=0 (operator acknowledge). Otherwise stay in ALARM.
  3. systemOn=0 → IDLE.
  4. IDLE:
     - tank empty → REFILL;
     - else soilDry → IRRIGATE, and the min counter is cleared;
     - else stay in IDLE.
  5. IRRIGATE:
     - tank empty → REFILL (overrides the minimum time);
     - else soilWet AND min counter ≥ MIN_IRRIGATION_CYCLES-1 → IDLE;
     - else stay. Moderate soil (dry=0, wet=0) keeps irrigating.
  6. REFILL: tank full → IDLE; otherwise stay.
- Min counter increments every cycle spent in IRRIGATE, saturates at MIN_IRRIGATION_CYCLES-1, and clears on IRRIGATE entry.
- State encoding: IDLE=00, IRRIGATE=01, REFILL=10, ALARM=11.
- Outputs are a pure decode of the state register (glitch-free, no input path):
  - irrigationRequest = (state==IRRIGATE);
  - valveFill = (state==REFILL);
  - alarm = (state==ALARM).
- irrigationRequest and valveFill are never both 1.
- Reset asserted mid-IRRIGATE or mid-REFILL drops all outputs immediately (asynchronously). A re-debounce is required before any action.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE, ST_IRRIGATE, ST_REFILL, ST_ALARM);
  - tank codes (TANK_EMPTY=3'b000, TANK_FULL=3'b111);
  - sensor-vector bit indices.
- One sub-module, `sensor_debounce`: 2-FF sync, counter, accepted-vector register and `sensorsValid` flag. Parameterised by width and DEBOUNCE_CYCLES.
- Validity check and FSM stay in the top module.

Test Plan:
1. Reset, then systemOn=1, tank=111, soilDry=1 held → IDLE until `sensorsValid`. irrigationRequest=1 exactly 3+DEBOUNCE_CYCLES (=7) edges after release. valveFill=0.
2. In IRRIGATE, drive soilWet=1, soilDry=0 at IRRIGATE cycle 3 → request stays 1 until the min counter reaches 15, then IDLE. Total request high ≥16 cycles.
3. In IRRIGATE, set tank to 000 → REFILL: irrigationRequest=0, valveFill=1. Raise tank 100→110→111 → IDLE after the 111 debounce.
4. Drive soilDry=soilWet=1 from IRRIGATE → ALARM=1, request=0. Clear the fault with systemOn=1 → stays ALARM. Set systemOn=0 → IDLE.
5. Tank=010 (invalid thermometer) from REFILL → ALARM. A 2-cycle glitch of soilDry while idle (DEBOUNCE_CYCLES=4) → no state change.
6. Assert resetBar=0 mid-REFILL between clock edges → valveFill=0 and state=00 without waiting for an edge.
